// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - fetch-stage bus: instruction memory port, decode handshake, redirect
interface instr_fetch_unit_if #(
    parameter int PC_W    = 10,
    parameter int INSTR_W = 24
);
    // Instruction memory request/response
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_valid;
    logic [INSTR_W-1:0] imem_data;

    // Presented instruction towards control unit / decode
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [3:0]         opcode;
    logic [PC_W-1:0]    instr_pc;

    // Branch resolution redirect
    logic               redirect;
    logic [PC_W-1:0]    redirect_pc;

    // Halt status
    logic               halted;

    modport master (
        output imem_req, imem_addr,
        input  imem_valid, imem_data,
        output instr_valid, instr, opcode, instr_pc,
        input  instr_ready,
        input  redirect, redirect_pc,
        output halted
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_valid, imem_data,
        input  instr_valid, instr, opcode, instr_pc,
        output instr_ready,
        output redirect, redirect_pc,
        input  halted
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch stage; optional halt-on-0xF opcode via IFETCH_HALT_EN
module instr_fetch_unit #(
    parameter int              PC_W     = 10,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              INSTR_W  = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    instr_fetch_unit_if.master    bus
);

`ifdef IFETCH_HALT_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_HOLD,
        ST_HALTED
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_HOLD
    } state_t;
`endif

    localparam logic [PC_W-1:0] PC_ONE = 1;

    state_t             state, state_n;
    logic [PC_W-1:0]    pc, pc_n;
    // Set when the outstanding request was issued for a PC that has since been redirected away from
    logic               kill, kill_n;
    logic [INSTR_W-1:0] instr_q, instr_n;
    logic [PC_W-1:0]    instr_pc_q, instr_pc_n;
    logic               valid_q, valid_n;

`ifdef IFETCH_HALT_EN
    logic               halted_q, halted_n;
    logic               halt_op;

    assign halt_op = (instr_q[INSTR_W-1 -: 4] == 4'hF);
`endif

    // Outputs come only from registers or the state decode; nothing passes combinationally from inputs
    assign bus.imem_req    = (state == ST_FETCH);
    assign bus.imem_addr   = pc;
    assign bus.instr_valid = valid_q;
    assign bus.instr       = instr_q;
    assign bus.opcode      = instr_q[INSTR_W-1 -: 4];
    assign bus.instr_pc    = instr_pc_q;
`ifdef IFETCH_HALT_EN
    assign bus.halted      = halted_q;
`else
    assign bus.halted      = 1'b0;
`endif

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            pc         <= RESET_PC;
            kill       <= 1'b0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
`ifdef IFETCH_HALT_EN
            halted_q   <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            kill       <= kill_n;
            instr_q    <= instr_n;
            instr_pc_q <= instr_pc_n;
            valid_q    <= valid_n;
`ifdef IFETCH_HALT_EN
            halted_q   <= halted_n;
`endif
        end
    end

    // Next-state logic; redirect outranks every other event in every state
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        kill_n     = kill;
        instr_n    = instr_q;
        instr_pc_n = instr_pc_q;
        valid_n    = valid_q;
`ifdef IFETCH_HALT_EN
        halted_n   = halted_q;
`endif
        case (state)
            ST_IDLE: begin
                state_n = ST_FETCH;
                if (bus.redirect) begin
                    pc_n = bus.redirect_pc;
                end
            end

            ST_FETCH: begin
                // The request already left with the old PC, so its response must be dropped
                state_n = ST_WAIT;
                if (bus.redirect) begin
                    pc_n   = bus.redirect_pc;
                    kill_n = 1'b1;
                end
            end

            ST_WAIT: begin
                if (bus.redirect) begin
                    pc_n = bus.redirect_pc;
                    if (bus.imem_valid) begin
                        // The stale response lands in the redirect cycle itself: nothing left to kill
                        kill_n  = 1'b0;
                        state_n = ST_FETCH;
                    end else begin
                        kill_n = 1'b1;
                    end
                end else if (bus.imem_valid) begin
                    if (kill) begin
                        kill_n  = 1'b0;
                        state_n = ST_FETCH;
                    end else begin
                        instr_n    = bus.imem_data;
                        instr_pc_n = pc;
                        valid_n    = 1'b1;
                        state_n    = ST_HOLD;
                    end
                end
            end

            ST_HOLD: begin
                if (bus.redirect) begin
                    pc_n    = bus.redirect_pc;
                    valid_n = 1'b0;
                    state_n = ST_FETCH;
                end else if (bus.instr_ready) begin
                    valid_n = 1'b0;
                    pc_n    = pc + PC_ONE;
                    state_n = ST_FETCH;
`ifdef IFETCH_HALT_EN
                    if (halt_op) begin
                        pc_n     = pc;
                        halted_n = 1'b1;
                        state_n  = ST_HALTED;
                    end
`endif
                end
            end

`ifdef IFETCH_HALT_EN
            ST_HALTED: begin
                if (bus.redirect) begin
                    pc_n     = bus.redirect_pc;
                    halted_n = 1'b0;
                    state_n  = ST_FETCH;
                end
            end
`endif

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 24;

    logic clk = 1'b0;
    logic rst;

    instr_fetch_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

    instr_fetch_unit #(.PC_W(PC_W), .RESET_PC('0), .INSTR_W(INSTR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } exp_t;

    exp_t               sb_q[$];
    logic [INSTR_W-1:0] mem [0:(1<<PC_W)-1];
    int                 tests = 0;
    int                 fails = 0;
    int                 cycle = 0;
    int                 valid_cycle = 0;
    int                 lat = 1;
    int                 t0, t1;

    // Memory model state, owned by the responder process
    bit                 pend = 1'b0;
    int                 cnt = 0;
    logic [PC_W-1:0]    paddr = '0;

    always @(posedge clk) cycle <= cycle + 1;

    // Instruction memory: answers each request lat cycles later
    always @(negedge clk) begin
        if (rst) begin
            pend = 1'b0;
            bus.imem_valid = 1'b0;
            bus.imem_data = '0;
        end else begin
            bus.imem_valid = 1'b0;
            if (pend) begin
                if (cnt <= 1) begin
                    bus.imem_valid = 1'b1;
                    bus.imem_data = mem[paddr];
                    pend = 1'b0;
                end else begin
                    cnt = cnt - 1;
                end
            end
            if (bus.imem_req === 1'b1) begin
                pend = 1'b1;
                cnt = lat;
                paddr = bus.imem_addr;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [PC_W-1:0] pc);
        exp_t e;
        e.pc = pc;
        e.instr = mem[pc];
        sb_q.push_back(e);
    endtask

    task automatic wait_instr(input bit accept);
        int n;
        exp_t e;
        n = 0;
        while (bus.instr_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        valid_cycle = cycle;
        check("instr_valid_seen", bus.instr_valid, 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
        end else begin
            e.pc = '0;
            e.instr = '0;
        end
        check("instr", bus.instr, e.instr);
        check("opcode", bus.opcode, e.instr[INSTR_W-1 -: 4]);
        check("instr_pc", bus.instr_pc, e.pc);
        if (accept) begin
            bus.instr_ready = 1'b1;
            tick();
            bus.instr_ready = 1'b0;
        end
    endtask

    task automatic expect_req(input string tag, input logic [PC_W-1:0] addr);
        int n;
        n = 0;
        while (bus.imem_req !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_req"}, bus.imem_req, 1);
        check({tag, "_addr"}, bus.imem_addr, addr);
    endtask

    task automatic redirect_to(input logic [PC_W-1:0] pc);
        bus.redirect = 1'b1;
        bus.redirect_pc = pc;
        tick();
        bus.redirect = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        bus.instr_ready = 1'b0;
        for (int i = 0; i < (1 << PC_W); i++) begin
            mem[i] = {4'h1, 10'(i), 10'(i ^ 'h155)};
        end
        mem[0]     = 24'h612345;
        mem[1]     = 24'h2ABCDE;
        mem[10'h40] = 24'h5A0040;
        mem[10'h20] = 24'hF00000;
        tick();
        tick();

        // Reset values
        check("rst_req", bus.imem_req, 0);
        check("rst_valid", bus.instr_valid, 0);
        check("rst_instr", bus.instr, 0);
        check("rst_opcode", bus.opcode, 0);
        check("rst_instr_pc", bus.instr_pc, 0);
        check("rst_halted", bus.halted, 0);
        rst = 1'b0;
        check("idle_no_req", bus.imem_req, 0);
        tick();
        check("first_req", bus.imem_req, 1);
        check("first_addr", bus.imem_addr, 0);

        // Sequential fetch, L=1
        push_exp(0);
        wait_instr(1);
        t0 = valid_cycle;
        expect_req("seq1", 1);
        push_exp(1);
        wait_instr(0);
        t1 = valid_cycle;
        check("seq_period", t1 - t0, 3);

        // Back-pressure in HOLD
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", bus.instr_valid, 1);
            check("bp_instr", bus.instr, 24'h2ABCDE);
            check("bp_instr_pc", bus.instr_pc, 1);
            check("bp_no_req", bus.imem_req, 0);
        end
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        check("bp_req", bus.imem_req, 1);
        check("bp_addr", bus.imem_addr, 2);
        push_exp(2);
        wait_instr(0);

        // Redirect in WAIT with L=4, two cycles after the request
        lat = 4;
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        check("rw_req", bus.imem_req, 1);
        check("rw_addr", bus.imem_addr, 3);
        tick();
        tick();
        redirect_to(10'h040);
        n = 0;
        while (bus.imem_req !== 1'b1 && n < 20) begin
            check("rw_drop_valid", bus.instr_valid, 0);
            tick();
            n++;
        end
        check("rw_new_req", bus.imem_req, 1);
        check("rw_new_addr", bus.imem_addr, 10'h040);
        push_exp(10'h040);
        wait_instr(0);
        lat = 1;

        // Redirect together with InstrReady in HOLD: no PC+1
        bus.instr_ready = 1'b1;
        redirect_to(10'h100);
        bus.instr_ready = 1'b0;
        check("hr_req", bus.imem_req, 1);
        check("hr_addr", bus.imem_addr, 10'h100);
        check("hr_valid", bus.instr_valid, 0);

        // Redirect coinciding with the response in WAIT
        tick();
        redirect_to(10'h200);
        check("co_req", bus.imem_req, 1);
        check("co_addr", bus.imem_addr, 10'h200);
        check("co_valid", bus.instr_valid, 0);
        push_exp(10'h200);
        wait_instr(0);

        // PC wrap at 0x3FF
        lat = 4;
        redirect_to(10'h3FF);
        check("wr_req", bus.imem_req, 1);
        check("wr_addr", bus.imem_addr, 10'h3FF);
        push_exp(10'h3FF);
        wait_instr(1);
        check("wrap_req", bus.imem_req, 1);
        check("wrap_addr", bus.imem_addr, 0);

        // Reset asserted in WAIT
        tick();
        rst = 1'b1;
        #1;
        check("rs_req", bus.imem_req, 0);
        check("rs_valid", bus.instr_valid, 0);
        check("rs_instr", bus.instr, 0);
        check("rs_opcode", bus.opcode, 0);
        check("rs_instr_pc", bus.instr_pc, 0);
        check("rs_halted", bus.halted, 0);
        tick();
        tick();
        rst = 1'b0;
        lat = 1;
        check("rs_idle", bus.imem_req, 0);
        tick();
        check("rs_first_req", bus.imem_req, 1);
        check("rs_first_addr", bus.imem_addr, 0);
        push_exp(0);
        wait_instr(0);

        // Opcode 4'hF: halts only when the feature is built in
        redirect_to(10'h020);
        check("h_req", bus.imem_req, 1);
        check("h_addr", bus.imem_addr, 10'h020);
        push_exp(10'h020);
        wait_instr(1);
`ifdef IFETCH_HALT_EN
        check("h_halted", bus.halted, 1);
        check("h_valid", bus.instr_valid, 0);
        for (int i = 0; i < 10; i++) begin
            check("h_no_req", bus.imem_req, 0);
            tick();
        end
        check("h_still_halted", bus.halted, 1);
        redirect_to(10'h010);
        check("h_resume_halted", bus.halted, 0);
        check("h_resume_req", bus.imem_req, 1);
        check("h_resume_addr", bus.imem_addr, 10'h010);
        push_exp(10'h010);
        wait_instr(1);
`else
        check("nh_halted", bus.halted, 0);
        check("nh_req", bus.imem_req, 1);
        check("nh_addr", bus.imem_addr, 10'h021);
        push_exp(10'h021);
        wait_instr(1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage of the 24-bit single-cycle CPU. Holds the program counter and issues one request at a time to instruction memory, which has variable latency. Captures the returned 24-bit word into an instruction register and presents it, with its 4-bit opcode, to the control unit and decode logic under a valid/ready handshake. Redirects from branch resolution override sequential fetch, and any stale in-flight response is discarded.

## Interface
- PC_W, 10, program counter width; word-addressed, one instruction per address
- RESET_PC, 0, PC value loaded on reset
- INSTR_W, 24, instruction width; opcode is Instr[INSTR_W-1:INSTR_W-4]
- Clock  input  1  rising-edge clock; the block's only clock
- Reset  input  1  asynchronous, active-high reset
- ImemReq  output  1  single-cycle request pulse to instruction memory
- ImemAddr  output  PC_W  request address; equals the current PC
- ImemValid  input  1  response strobe, 1 or more cycles after ImemReq
- ImemData  input  INSTR_W  response word, qualified by ImemValid
- InstrValid  output  1  Instr, OPCODE and InstrPc are valid
- InstrReady  input  1  consumer accepts the instruction this cycle
- Instr  output  INSTR_W  instruction register
- OPCODE  output  4  Instr[INSTR_W-1:INSTR_W-4], feeds the control unit
- InstrPc  output  PC_W  address of the presented instruction
- Redirect  input  1  branch taken; load RedirectPc
- RedirectPc  input  PC_W  redirect target
- Halted  output  1  fetch stopped on a halt opcode; tied 0 without the macro

## Operation
- States are IDLE, FETCH, WAIT and HOLD. A fifth state, HALTED, exists only with the macro.
- Reset: state IDLE; PC=RESET_PC; Kill=0; Instr=0; InstrPc=0; InstrValid=0; ImemReq=0; Halted=0.
- IDLE: go to FETCH unconditionally on the next clock.
- FETCH: ImemReq=1 for this cycle only, with ImemAddr=PC; go to WAIT.
- WAIT, ImemValid=1 and Kill=1: discard ImemData; clear Kill; go to FETCH.
- WAIT, ImemValid=1 and Kill=0: Instr<=ImemData; InstrPc<=PC; InstrValid<=1; go to HOLD.
- HOLD: hold InstrValid=1 and all outputs stable until InstrReady=1.
- HOLD with InstrReady=1: PC<=PC+1 (mod 2^PC_W); InstrValid<=0; go to FETCH.
- Only one request is outstanding at a time. ImemReq is never asserted in WAIT, HOLD, IDLE or HALTED.
- Redirect always takes priority, and in every case PC<=RedirectPc:
  - In IDLE: go to FETCH.
  - In FETCH: the request still issues with the old PC; set Kill; go to WAIT.
  - In WAIT without ImemValid: set Kill; stay in WAIT.
  - In WAIT with ImemValid in the same cycle: discard the data; go to FETCH; Kill stays 0.
  - In HOLD, with or without InstrReady: InstrValid<=0; go to FETCH. There is no PC+1.
- A killed response is never presented; InstrValid never rises for it.
- InstrReady is ignored when InstrValid=0.

## Timing
- Fetch latency is 1 cycle in FETCH plus memory latency L. InstrValid rises on the clock edge that samples ImemValid.
- With L=1 and InstrReady held at 1, one instruction is delivered every 3 cycles.
- After Reset deasserts, the first ImemReq appears in the 2nd cycle, because IDLE lasts one cycle.
- From Redirect to the first new ImemReq:
  - 1 cycle from HOLD or IDLE.
  - From FETCH or WAIT, the old response must first return and be dropped.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.
- Reset asserted mid-operation clears state immediately. A memory response arriving after reset deasserts is ignored unless the block is in WAIT.

## Configuration
- IFETCH_HALT_EN defined:
  - A captured instruction with opcode 4'b1111 is presented normally in HOLD.
  - Once it is accepted (InstrReady=1, no Redirect), go to HALTED: no requests, InstrValid=0, Halted=1, PC unchanged.
  - HALTED exits only on Reset, or on Redirect (go to FETCH with PC=RedirectPc, Halted<=0).
  - Redirect in the accept cycle wins over halt.
- IFETCH_HALT_EN undefined: opcode 4'b1111 is fetched like any other opcode; there is no HALTED state; Halted is tied 0.

## Test plan
- Sequential fetch: reset, memory L=1, words 0x612345 at address 0 and 0x2ABCDE at address 1, InstrReady=1. Required: ImemAddr 0 then 1; OPCODE 4'h6 then 4'h2; InstrPc 0 then 1; one instruction every 3 cycles.
- Back-pressure: InstrReady=0 for 5 cycles in HOLD. Required: Instr, InstrPc and InstrValid stable; no ImemReq; PC advances exactly once after InstrReady=1.
- Redirect in WAIT: L=4, Redirect with RedirectPc=0x040 two cycles after the request. Required: the old response is dropped with InstrValid kept 0; the next ImemReq uses ImemAddr=0x040; InstrPc=0x040.
- Redirect with InstrReady in HOLD, and redirect coinciding with ImemValid in WAIT. Required in both cases: no PC+1; the next fetch goes to RedirectPc; Kill stays 0 in the coincident case.
- Wrap and reset: PC=0x3FF is accepted, so PC becomes 0x000. Then assert Reset during WAIT. Required: all outputs return to their reset values; the next ImemReq is to RESET_PC.
- Halt (IFETCH_HALT_EN): fetch 0xF00000, then accept it. Required: Halted=1; no further ImemReq for 10 cycles; Redirect to 0x010 resumes fetch with Halted=0.
